// File: rtl/hpdcache_store_wbuf.sv
// Store write buffer between the store unit and the HPDcache: an in-order FIFO of committed
// stores that coalesces into the newest entry and flags loads overlapping any buffered store.
module hpdcache_store_wbuf #(
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      st_valid_i,
    output logic                      st_ready_o,
    input  logic [ADDR_WIDTH-1:0]     st_addr_i,
    input  logic [DATA_WIDTH-1:0]     st_data_i,
    input  logic [DATA_WIDTH/8-1:0]   st_be_i,
    output logic                      req_valid_o,
    input  logic                      req_ready_i,
    output logic [ADDR_WIDTH-1:0]     req_addr_o,
    output logic [DATA_WIDTH-1:0]     req_data_o,
    output logic [DATA_WIDTH/8-1:0]   req_be_o,
    input  logic [ADDR_WIDTH-1:0]     ld_addr_i,
    input  logic [DATA_WIDTH/8-1:0]   ld_be_i,
    output logic                      ld_hit_o,
    output logic                      empty_o,
    output logic                      full_o,
    output logic [$clog2(DEPTH):0]    count_o
);
    localparam int BE_W   = DATA_WIDTH / 8;
    localparam int OFS    = $clog2(BE_W);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int WORD_W = ADDR_WIDTH - OFS;
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0] TWO_CNT  = (PTR_W + 1)'(2);

    logic [WORD_W-1:0]     word_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [BE_W-1:0]       be_q   [DEPTH];
    logic [DEPTH-1:0]      valid_q;
    logic [PTR_W-1:0]      head_q;
    logic [PTR_W-1:0]      tail_q;
    logic [PTR_W-1:0]      newest;
    logic [PTR_W:0]        count_q;
    logic [WORD_W-1:0]     st_word;
    logic [WORD_W-1:0]     ld_word;
    logic                  merge;
    logic                  push;
    logic                  pop;
    logic                  unused_ofs;

    assign st_word    = st_addr_i[ADDR_WIDTH-1:OFS];
    assign ld_word    = ld_addr_i[ADDR_WIDTH-1:OFS];
    assign unused_ofs = ^{st_addr_i[OFS-1:0], ld_addr_i[OFS-1:0]};
    assign newest     = tail_q - PTR_W'(1);

    // Requiring two entries keeps the head out of reach of a merge, so req_* never change under a stall.
    assign merge      = st_valid_i && (count_q >= TWO_CNT) && (word_q[newest] == st_word);
    assign push       = st_valid_i && !merge && (count_q < FULL_CNT);
    assign pop        = (count_q != '0) && req_ready_i;
    assign st_ready_o = merge || (count_q < FULL_CNT);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            if (push) begin
                tail_q          <= tail_q + PTR_W'(1);
                valid_q[tail_q] <= 1'b1;
            end
            if (pop) begin
                head_q          <= head_q + PTR_W'(1);
                valid_q[head_q] <= 1'b0;
            end
            if (push && !pop) begin
                count_q <= count_q + (PTR_W + 1)'(1);
            end else if (!push && pop) begin
                count_q <= count_q - (PTR_W + 1)'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            word_q[tail_q] <= st_word;
            data_q[tail_q] <= st_data_i;
            be_q[tail_q]   <= st_be_i;
        end else if (merge) begin
            for (int i = 0; i < BE_W; i++) begin
                if (st_be_i[i]) begin
                    data_q[newest][8*i +: 8] <= st_data_i[8*i +: 8];
                    be_q[newest][i]          <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        ld_hit_o = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (word_q[i] == ld_word) && ((be_q[i] & ld_be_i) != '0)) begin
                ld_hit_o = 1'b1;
            end
        end
    end

    assign req_valid_o = (count_q != '0);
    assign req_addr_o  = {word_q[head_q], {OFS{1'b0}}};
    assign req_data_o  = data_q[head_q];
    assign req_be_o    = be_q[head_q];
    assign empty_o     = (count_q == '0);
    assign full_o      = (count_q == FULL_CNT);
    assign count_o     = count_q;

endmodule

// File: tb/tb_hpdcache_store_wbuf.sv
// Bench for hpdcache_store_wbuf: directed scenarios plus random traffic, all checked
// against a queue-based model of the buffer's FIFO/coalescing rules.
module tb_hpdcache_store_wbuf;
    localparam int DEPTH = 8;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        st_valid_i;
    logic        st_ready_o;
    logic [63:0] st_addr_i;
    logic [63:0] st_data_i;
    logic [7:0]  st_be_i;
    logic        req_valid_o;
    logic        req_ready_i;
    logic [63:0] req_addr_o;
    logic [63:0] req_data_o;
    logic [7:0]  req_be_o;
    logic [63:0] ld_addr_i;
    logic [7:0]  ld_be_i;
    logic        ld_hit_o;
    logic        empty_o;
    logic        full_o;
    logic [3:0]  count_o;

    hpdcache_store_wbuf #(.DEPTH(DEPTH), .ADDR_WIDTH(64), .DATA_WIDTH(64)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .st_valid_i(st_valid_i), .st_ready_o(st_ready_o), .st_addr_i(st_addr_i),
        .st_data_i(st_data_i), .st_be_i(st_be_i),
        .req_valid_o(req_valid_o), .req_ready_i(req_ready_i), .req_addr_o(req_addr_o),
        .req_data_o(req_data_o), .req_be_o(req_be_o),
        .ld_addr_i(ld_addr_i), .ld_be_i(ld_be_i), .ld_hit_o(ld_hit_o),
        .empty_o(empty_o), .full_o(full_o), .count_o(count_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [60:0] word;
        logic [63:0] data;
        logic [7:0]  be;
    } entry_t;

    entry_t model_q[$];
    int     check_count = 0;
    int     pass_count  = 0;
    logic   last_st_ready;
    logic   last_ld_hit;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        check_count++;
        if (observed === expected) pass_count++;
        else $display("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    endtask

    function automatic logic modelLdHit(input logic [63:0] addr, input logic [7:0] be);
        foreach (model_q[i]) begin
            if (model_q[i].word == addr[63:3] && (model_q[i].be & be) != 8'h00) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic checkState();
        checkOutput("count", 64'(count_o), 64'(model_q.size()));
        checkOutput("empty", 64'(empty_o), 64'(model_q.size() == 0));
        checkOutput("full", 64'(full_o), 64'(model_q.size() == DEPTH));
        checkOutput("req_valid", 64'(req_valid_o), 64'(model_q.size() != 0));
        if (model_q.size() != 0) begin
            checkOutput("req_addr", req_addr_o, {model_q[0].word, 3'b000});
            checkOutput("req_data", req_data_o, model_q[0].data);
            checkOutput("req_be", 64'(req_be_o), 64'(model_q[0].be));
        end
    endtask

    // One clock cycle: drive at posedge+1, check at negedge, advance the model at posedge.
    task automatic applyStimulus(input logic v, input logic [63:0] addr, input logic [63:0] data,
                                 input logic [7:0] be, input logic rdy,
                                 input logic [63:0] la, input logic [7:0] lbe);
        logic   mrg, psh, pp;
        entry_t e;
        st_valid_i  = v;
        st_addr_i   = addr;
        st_data_i   = data;
        st_be_i     = be;
        req_ready_i = rdy;
        ld_addr_i   = la;
        ld_be_i     = lbe;
        mrg = v && model_q.size() >= 2 && model_q[model_q.size()-1].word == addr[63:3];
        psh = v && !mrg && model_q.size() < DEPTH;
        pp  = rdy && model_q.size() != 0;
        @(negedge clk_i);
        last_st_ready = st_ready_o;
        last_ld_hit   = ld_hit_o;
        checkState();
        checkOutput("st_ready", 64'(st_ready_o), 64'(mrg || model_q.size() < DEPTH));
        checkOutput("ld_hit", 64'(ld_hit_o), 64'(modelLdHit(la, lbe)));
        @(posedge clk_i);
        if (mrg) begin
            e = model_q[model_q.size()-1];
            for (int i = 0; i < 8; i++) begin
                if (be[i]) begin
                    e.data[8*i +: 8] = data[8*i +: 8];
                    e.be[i] = 1'b1;
                end
            end
            model_q[model_q.size()-1] = e;
        end
        if (pp) void'(model_q.pop_front());
        if (psh) begin
            e.word = addr[63:3];
            e.data = data;
            e.be   = be;
            model_q.push_back(e);
        end
        #1;
    endtask

    task automatic drain();
        for (int n = 0; n < 2 * DEPTH && model_q.size() != 0; n++) applyStimulus(0, 0, 0, 0, 1, 0, 0);
        checkOutput("drain_empty", 64'(empty_o), 64'h1);
    endtask

    function automatic logic [63:0] poolAddr();
        return 64'h8000_0000 + 64'($urandom_range(0, 5) * 8) + 64'($urandom_range(0, 7));
    endfunction

    initial begin
        rst_ni = 1'b0; st_valid_i = 1'b0; st_addr_i = '0; st_data_i = '0; st_be_i = '0;
        req_ready_i = 1'b0; ld_addr_i = 64'h8000_0000; ld_be_i = 8'hFF;
        #12;
        checkOutput("rst_req_valid", 64'(req_valid_o), 64'h0);
        checkOutput("rst_empty", 64'(empty_o), 64'h1);
        checkOutput("rst_full", 64'(full_o), 64'h0);
        checkOutput("rst_count", 64'(count_o), 64'h0);
        checkOutput("rst_ld_hit", 64'(ld_hit_o), 64'h0);
        @(negedge clk_i) rst_ni = 1'b1;
        @(posedge clk_i); #1;
        repeat (3) applyStimulus(0, 0, 0, 0, 0, poolAddr(), 8'($urandom));

        // Single store held under backpressure
        applyStimulus(1, 64'h8000_0010, 64'h1122_3344_5566_7788, 8'hFF, 0, 0, 0);
        checkOutput("single_st_ready", 64'(last_st_ready), 64'h1);
        checkOutput("single_req_valid", 64'(req_valid_o), 64'h1);
        checkOutput("single_req_addr", req_addr_o, 64'h8000_0010);
        repeat (5) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0);
            checkOutput("single_stable_addr", req_addr_o, 64'h8000_0010);
            checkOutput("single_stable_data", req_data_o, 64'h1122_3344_5566_7788);
        end
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        checkOutput("single_empty", 64'(empty_o), 64'h1);

        // Coalescing into the newest entry
        applyStimulus(1, 64'h8000_0000, 64'h0102_0304_0506_0708, 8'hFF, 0, 0, 0);
        applyStimulus(1, 64'h8000_0008, 64'h0000_0000_0000_00AA, 8'h01, 0, 0, 0);
        applyStimulus(1, 64'h8000_000C, 64'h0000_00BB_0000_0000, 8'h10, 0, 0, 0);
        checkOutput("coal_count", 64'(count_o), 64'h2);
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        checkOutput("coal_addr", req_addr_o, 64'h8000_0008);
        checkOutput("coal_be", 64'(req_be_o), 64'h11);
        checkOutput("coal_byte0", 64'(req_data_o[7:0]), 64'hAA);
        checkOutput("coal_byte4", 64'(req_data_o[39:32]), 64'hBB);
        drain();

        // Second store to the head word must not merge
        applyStimulus(1, 64'h8000_0000, 64'h1, 8'h0F, 0, 0, 0);
        applyStimulus(1, 64'h8000_0000, 64'h2, 8'hF0, 0, 0, 0);
        checkOutput("nohead_count", 64'(count_o), 64'h2);
        checkOutput("nohead_first_be", 64'(req_be_o), 64'h0F);
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        checkOutput("nohead_second_be", 64'(req_be_o), 64'hF0);
        checkOutput("nohead_second_addr", req_addr_o, 64'h8000_0000);
        drain();

        // Full buffer: distinct store stalls even with a pop, merge still accepted
        for (int k = 0; k < DEPTH; k++) applyStimulus(1, 64'h8000_1000 + 64'(k * 8), 64'(k), 8'hFF, 0, 0, 0);
        checkOutput("full_flag", 64'(full_o), 64'h1);
        applyStimulus(1, 64'h8000_2000, 64'h9, 8'hFF, 1, 0, 0);
        checkOutput("full_stall", 64'(last_st_ready), 64'h0);
        checkOutput("full_after_pop", 64'(count_o), 64'h7);
        applyStimulus(1, 64'h8000_2000, 64'h9, 8'hFF, 0, 0, 0);
        checkOutput("full_again", 64'(full_o), 64'h1);
        applyStimulus(1, 64'h8000_2004, 64'hFFFF_FFFF_0000_0000, 8'hF0, 0, 0, 0);
        checkOutput("full_merge_ready", 64'(last_st_ready), 64'h1);
        checkOutput("full_merge_count", 64'(count_o), 64'h8);
        drain();

        // Load hazard byte-lane overlap
        applyStimulus(1, 64'h8000_0020, 64'h1234, 8'h0F, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 64'h8000_0024, 8'hF0);
        checkOutput("ld_no_overlap", 64'(last_ld_hit), 64'h0);
        applyStimulus(0, 0, 0, 0, 0, 64'h8000_0024, 8'h08);
        checkOutput("ld_overlap", 64'(last_ld_hit), 64'h1);
        applyStimulus(0, 0, 0, 0, 1, 64'h8000_0024, 8'h08);
        checkOutput("ld_popping_head", 64'(last_ld_hit), 64'h1);
        applyStimulus(0, 0, 0, 0, 0, 64'h8000_0024, 8'h08);
        checkOutput("ld_after_pop", 64'(last_ld_hit), 64'h0);

        // Random traffic with one asynchronous reset in the middle
        for (int n = 0; n < 1500; n++) begin
            if (n == 700) begin
                st_valid_i = 1'b0;
                req_ready_i = 1'b0;
                #2 rst_ni = 1'b0;
                #1;
                checkOutput("mid_rst_req_valid", 64'(req_valid_o), 64'h0);
                checkOutput("mid_rst_count", 64'(count_o), 64'h0);
                checkOutput("mid_rst_empty", 64'(empty_o), 64'h1);
                checkOutput("mid_rst_ld_hit", 64'(ld_hit_o), 64'h0);
                model_q.delete();
                @(negedge clk_i) rst_ni = 1'b1;
                @(posedge clk_i); #1;
                repeat (3) applyStimulus(0, 0, 0, 0, 1, poolAddr(), 8'($urandom));
            end
            applyStimulus($urandom_range(0, 99) < 65, poolAddr(), {$urandom, $urandom}, 8'($urandom),
                          $urandom_range(0, 99) < 35, poolAddr(), 8'($urandom));
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end
endmodule
